mem_access_stage: RTL and testbench

- MEM pipeline stage placed directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs (ALU result, rd, MemRead/MemtoReg/MemWrite/RegWrite, forwarded rt data) and runs one word access per instruction on a variable-latency data-memory req/ready interface.
- Stalls the upstream pipeline while an access is pending.
- Registers the MEM/WB pipeline outputs. Includes an access-timeout watchdog and misalignment detection.

---
 rtl/mips_pipe_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 21 ++
 rtl/mem_access_stage.sv | 92 +++++++++
 tb/tb_mem_access_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, MEM-stage FSM states and the MEM/WB bundle.
package mips_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int RD_W = 5;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] memdata;
    logic [RD_W-1:0]   rd;
    logic              memtoreg;
    logic              regwrite;
  } mem_wb_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: clear/enable counter flagging when it sits at its terminal count.
module mem_timeout_ctr #(
  parameter int CNT_W = 5,
  parameter int TC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    tc = cnt_q == CNT_W'(TC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with variable-latency data-memory handshake,
// upstream stall, access watchdog, misalignment detection and the MEM/WB register.
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_aluresult,
  input  logic [RD_W-1:0]   mem_rd,
  input  logic              mem_memread,
  input  logic              mem_memtoreg,
  input  logic              mem_memwrite,
  input  logic              mem_regwrite,
  input  logic [DATA_W-1:0] mem_rtdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] wb_aluresult,
  output logic [DATA_W-1:0] wb_memdata,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic              bus_err,
  output logic              misalign_err
);
  mem_state_e state_q, state_d;
  mem_wb_t wb_q, wb_d, wb_new, wb_hold;
  logic bus_err_q, bus_err_d, misalign_err_q, misalign_err_d;
  logic mem_op, aligned, in_wait, ack, timeout_abort, cnt_tc;
  mem_timeout_ctr #(.CNT_W(CNT_W), .TC(TIMEOUT_CYCLES - 1)) u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!in_wait),
    .en(in_wait & !dmem_ready),
    .tc(cnt_tc)
  );
  // req and stall are gated by rst_n so a pending access is abandoned the moment reset asserts
  always_comb begin
    mem_op = mem_memread | mem_memwrite;
    aligned = mem_aluresult[1:0] == 2'b00;
    in_wait = state_q == MEM_WAIT;
    dmem_req = rst_n & (in_wait | (mem_op & aligned));
    dmem_we = mem_memwrite;
    dmem_addr = mem_aluresult;
    dmem_wdata = mem_rtdata;
    ack = dmem_req & dmem_ready;
    timeout_abort = in_wait & !dmem_ready & cnt_tc;
    stall_out = rst_n & mem_op & aligned & !ack & !timeout_abort;
    state_d = (dmem_req & !ack & !timeout_abort) ? MEM_WAIT : MEM_IDLE;
    wb_new.aluresult = mem_aluresult;
    wb_new.memdata = (mem_memread & !mem_memwrite) ? dmem_rdata : '0;
    wb_new.rd = mem_rd;
    wb_new.memtoreg = mem_memtoreg;
    wb_new.regwrite = mem_regwrite;
    wb_hold = wb_q;
    wb_hold.memtoreg = 1'b0;
    wb_hold.regwrite = 1'b0;
    wb_d = (ack | !mem_op) ? wb_new : wb_hold;
    bus_err_d = timeout_abort;
    misalign_err_d = mem_op & !aligned;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      wb_q <= '0;
      bus_err_q <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q <= wb_d;
      bus_err_q <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end
  always_comb begin
    wb_aluresult = wb_q.aluresult;
    wb_memdata = wb_q.memdata;
    wb_rd = wb_q.rd;
    wb_memtoreg = wb_q.memtoreg;
    wb_regwrite = wb_q.regwrite;
    bus_err = bus_err_q;
    misalign_err = misalign_err_q;
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of the MEM stage against a per-instruction model.
module tb_mem_access_stage;
  localparam int T = 16;
  logic clk = 0, rst_n = 0;
  logic [31:0] mem_aluresult = 0, mem_rtdata = 0, dmem_rdata = 0;
  logic [4:0] mem_rd = 0;
  logic mem_memread = 0, mem_memtoreg = 0, mem_memwrite = 0, mem_regwrite = 0, dmem_ready = 0;
  logic dmem_req, dmem_we, stall_out, wb_memtoreg, wb_regwrite, bus_err, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_aluresult, wb_memdata;
  logic [4:0] wb_rd;
  int checks = 0, failures = 0;
  logic [31:0] e_alu = 0, e_mem = 0;
  logic [4:0] e_rd = 0;
  logic e_mt = 0, e_rw = 0;

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_aluresult(mem_aluresult), .mem_rd(mem_rd),
    .mem_memread(mem_memread), .mem_memtoreg(mem_memtoreg), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_rtdata(mem_rtdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .wb_aluresult(wb_aluresult), .wb_memdata(wb_memdata), .wb_rd(wb_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_wb(input string name);
    checks++;
    if ({wb_aluresult, wb_memdata, wb_rd, wb_memtoreg, wb_regwrite} !== {e_alu, e_mem, e_rd, e_mt, e_rw}) begin
      failures++;
      $display("FAIL %s wb: got alu=%h mem=%h rd=%0d mt=%b rw=%b, want alu=%h mem=%h rd=%0d mt=%b rw=%b",
               name, wb_aluresult, wb_memdata, wb_rd, wb_memtoreg, wb_regwrite, e_alu, e_mem, e_rd, e_mt, e_rw);
    end
  endtask

  // One instruction held on the inputs; memory answers after lat wait cycles (lat > T means never).
  task automatic run_instr(input logic [31:0] alu, input logic [4:0] rd, input logic mr, mt, mw, rw,
                           input logic [31:0] rt, rdata, input int lat, input string name);
    int stalls, reqs, c, exp_stalls, exp_reqs;
    bit bad;
    logic op, al, abort;
    op = mr | mw;
    al = alu % 4 == 0;
    abort = op && al && lat > T;
    exp_stalls = (op && al) ? (abort ? T : lat) : 0;
    exp_reqs = (op && al) ? exp_stalls + 1 : 0;
    mem_aluresult = alu; mem_rd = rd; mem_memread = mr; mem_memtoreg = mt;
    mem_memwrite = mw; mem_regwrite = rw; mem_rtdata = rt; dmem_rdata = rdata;
    dmem_ready = lat == 0;
    stalls = 0; reqs = 0; bad = 0;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dmem_req) begin
        reqs++;
        if (dmem_we !== mw || dmem_addr !== alu || dmem_wdata !== rt) bad = 1;
      end
      if (c > 0 && wb_regwrite !== 1'b0) bad = 1;
      if (!stall_out) break;
      stalls++;
      @(posedge clk); #1;
      dmem_ready = c + 1 == lat;
    end
    @(posedge clk); #1;
    if (!op || (al && !abort)) begin
      e_alu = alu; e_mem = (mr && !mw) ? rdata : 0; e_rd = rd; e_mt = mt; e_rw = rw;
    end else begin
      e_mt = 0; e_rw = 0;
    end
    check_wb(name);
    checks++;
    if (c == 60 || stalls != exp_stalls) begin
      failures++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls);
    end
    checks++;
    if (reqs != exp_reqs) begin
      failures++; $display("FAIL %s req_cycles: got %0d want %0d", name, reqs, exp_reqs);
    end
    checks++;
    if (bus_err !== abort) begin
      failures++; $display("FAIL %s bus_err: got %b want %b", name, bus_err, abort);
    end
    checks++;
    if (misalign_err !== (op && !al)) begin
      failures++; $display("FAIL %s misalign_err: got %b want %b", name, misalign_err, op && !al);
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL %s bus_or_bubble: got bad=1 want 0", name);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    e_alu = 0; e_mem = 0; e_rd = 0; e_mt = 0; e_rw = 0;
    check_wb("reset");
    checks++;
    if ({dmem_req, stall_out, bus_err, misalign_err} !== 4'b0) begin
      failures++; $display("FAIL reset ctrl: got %b want 0000", {dmem_req, stall_out, bus_err, misalign_err});
    end
    rst_n = 1;
  endtask

  task automatic test_directed;
    run_instr(32'h1234, 5'd5, 0, 0, 0, 1, 32'h0, 32'h0, 0, "alu_pass");
    run_instr(32'h100, 5'd7, 1, 1, 0, 1, 32'h0, 32'hDEADBEEF, 0, "load_zero_wait");
    run_instr(32'h40, 5'd0, 0, 0, 1, 0, 32'hA5A5A5A5, 32'h0, 3, "store_wait3");
    run_instr(32'h80, 5'd9, 1, 1, 0, 1, 32'h0, 32'h11111111, 100, "load_timeout");
    run_instr(32'h84, 5'd9, 1, 1, 0, 1, 32'h0, 32'h22222222, T, "load_ready_at_limit");
    run_instr(32'h102, 5'd3, 1, 1, 0, 1, 32'h0, 32'h33333333, 0, "load_misaligned");
    run_instr(32'h5555, 5'd4, 0, 0, 0, 1, 32'h0, 32'h0, 0, "alu_after_err");
  endtask

  task automatic test_back_to_back;
    run_instr(32'h200, 5'd1, 1, 1, 0, 1, 0, 32'hCAFE0001, 0, "b2b_0");
    run_instr(32'h204, 5'd2, 1, 1, 0, 1, 0, 32'hCAFE0002, 0, "b2b_1");
    run_instr(32'h208, 5'd3, 1, 1, 1, 1, 32'h77, 32'hCAFE0003, 1, "b2b_rw_both");
  endtask

  task automatic test_reset_in_wait;
    mem_aluresult = 32'h300; mem_rd = 5'd12; mem_memread = 1; mem_memtoreg = 1;
    mem_memwrite = 0; mem_regwrite = 1; dmem_rdata = 32'hBEEF0300; dmem_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    e_alu = 0; e_mem = 0; e_rd = 0; e_mt = 0; e_rw = 0;
    checks++;
    if ({dmem_req, stall_out} !== 2'b00) begin
      failures++; $display("FAIL rst_in_wait req_stall: got %b want 00", {dmem_req, stall_out});
    end
    check_wb("rst_in_wait");
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall_out} !== 2'b11) begin
      failures++; $display("FAIL rst_release_reissue: got %b want 11", {dmem_req, stall_out});
    end
    @(posedge clk); #1;
    run_instr(32'h300, 5'd12, 1, 1, 0, 1, 0, 32'hBEEF0300, 0, "rst_release_done");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int k, r, lat;
      k = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      r = $urandom_range(0, 11);
      lat = r < 8 ? r % 5 : r == 8 ? T : r == 9 ? T - 1 : 100;
      run_instr(a, 5'($urandom), k == 1 || k == 3, 1'($urandom), k >= 2, 1'($urandom),
                $urandom, $urandom, lat, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
